// File: rtl/perf_event_monitor_if.sv
// Control/read-out bundle between a pipeline performance monitor and whoever drives it.
// The master side drives controls and event strobes; the slave (the monitor) returns counters and flags.
interface perf_event_monitor_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int IDX_W  = $clog2(NUM_CH + 1)
);
    logic              clear_i;
    logic              freeze_i;
    logic [NUM_CH-1:0] event_i;
    logic              snap_i;
    logic [IDX_W-1:0]  rd_idx_i;
    logic [CNT_W-1:0]  rd_data_o;
    logic [CNT_W-1:0]  cycle_o;
    logic              done_o;
    logic [NUM_CH-1:0] ovf_o;
    logic              snap_valid_o;

    modport master (
        output clear_i, freeze_i, event_i, snap_i, rd_idx_i,
        input  rd_data_o, cycle_o, done_o, ovf_o, snap_valid_o
    );

    modport slave (
        input  clear_i, freeze_i, event_i, snap_i, rd_idx_i,
        output rd_data_o, cycle_o, done_o, ovf_o, snap_valid_o
    );
endinterface

// File: rtl/perf_event_monitor.sv
// Pipeline performance monitor: cycle counter plus NUM_CH event counters, self-stop after
// MAX_CYC counted cycles, and a shadow snapshot bank read out through a combinational mux.
module perf_event_monitor #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 32,
    parameter int SAT_MODE = 0,
    parameter int MAX_CYC  = 30,
    parameter int IDX_W    = $clog2(NUM_CH + 1)
) (
    input  logic                 clk_i,
    input  logic                 start_i,
    perf_event_monitor_if.slave  bus
);
    typedef enum logic {ST_RUN, ST_DONE} state_t;

    localparam bit              HAS_LIMIT = (MAX_CYC != 0);
    localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(MAX_CYC - 1);
    localparam logic [IDX_W-1:0] CYC_IDX  = IDX_W'(NUM_CH);

    state_t               state_q;
    logic [CNT_W-1:0]     cycle_q;
    logic [CNT_W-1:0]     shadow_cyc_q;
    logic                 snap_valid_q;
    logic                 done_q;
    logic                 count_en;
    logic [NUM_CH-1:0]    ovf_vec;
    logic [NUM_CH*CNT_W-1:0] shadow_flat;
    logic [CNT_W-1:0]     rd_data;

    assign count_en = (state_q == ST_RUN) && !bus.freeze_i;

    // Cycle counter, run/done FSM and the cycle-count shadow share one block.
    always_ff @(posedge clk_i) begin
        if (!start_i || bus.clear_i) begin
            state_q      <= ST_RUN;
            cycle_q      <= '0;
            shadow_cyc_q <= '0;
            snap_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            if (bus.snap_i) begin
                shadow_cyc_q <= cycle_q;
                snap_valid_q <= 1'b1;
            end
            case (state_q)
                ST_RUN: begin
                    if (!bus.freeze_i) begin
                        cycle_q <= cycle_q + 1'b1;
                        if (HAS_LIMIT && (cycle_q == LAST_CYC)) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= ST_RUN;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic [CNT_W-1:0] shadow_q;
            logic             ovf_q;
            logic             ovf_d;

            // An increment from all-ones either wraps to zero or pins at all-ones; both flag overflow.
            always_comb begin
                cnt_d = cnt_q;
                ovf_d = ovf_q;
                if (count_en && bus.event_i[gi]) begin
                    if (cnt_q == {CNT_W{1'b1}}) begin
                        ovf_d = 1'b1;
                        cnt_d = (SAT_MODE != 0) ? {CNT_W{1'b1}} : '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                if (!start_i || bus.clear_i) begin
                    cnt_q    <= '0;
                    ovf_q    <= 1'b0;
                    shadow_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                    ovf_q <= ovf_d;
                    if (bus.snap_i) begin
                        shadow_q <= cnt_q;
                    end
                end
            end

            assign ovf_vec[gi]                     = ovf_q;
            assign shadow_flat[gi*CNT_W +: CNT_W] = shadow_q;
        end
    endgenerate

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (bus.rd_idx_i == IDX_W'(k)) begin
                rd_data = shadow_flat[k*CNT_W +: CNT_W];
            end
        end
        if (bus.rd_idx_i == CYC_IDX) begin
            rd_data = shadow_cyc_q;
        end
    end

    assign bus.rd_data_o    = rd_data;
    assign bus.cycle_o      = cycle_q;
    assign bus.done_o       = done_q;
    assign bus.ovf_o        = ovf_vec;
    assign bus.snap_valid_o = snap_valid_q;
endmodule

// File: tb/tb_perf_event_monitor.sv
// Directed bench: one default-sized monitor plus two 4-bit monitors (wrap and saturate);
// expectations are queued as stimulus is applied and popped when outputs are sampled.
module tb_perf_event_monitor;
    localparam int NUM_CH = 4;
    localparam int IDX_W  = $clog2(NUM_CH + 1);

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    logic clk;
    logic start;
    exp_t sb[$];
    int   vectors;
    int   errors;

    perf_event_monitor_if #(.NUM_CH(NUM_CH), .CNT_W(32)) m_if ();
    perf_event_monitor_if #(.NUM_CH(NUM_CH), .CNT_W(4))  w_if ();
    perf_event_monitor_if #(.NUM_CH(NUM_CH), .CNT_W(4))  s_if ();

    perf_event_monitor #(.NUM_CH(NUM_CH), .CNT_W(32), .SAT_MODE(0), .MAX_CYC(30)) u_main (
        .clk_i(clk), .start_i(start), .bus(m_if.slave));
    perf_event_monitor #(.NUM_CH(NUM_CH), .CNT_W(4), .SAT_MODE(0), .MAX_CYC(0)) u_wrap (
        .clk_i(clk), .start_i(start), .bus(w_if.slave));
    perf_event_monitor #(.NUM_CH(NUM_CH), .CNT_W(4), .SAT_MODE(1), .MAX_CYC(0)) u_sat (
        .clk_i(clk), .start_i(start), .bus(s_if.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
            $display("vec %0d %s observed=%0h expected=%0h", vectors, e.tag, obs, e.exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd_main(input int idx);
        m_if.rd_idx_i = IDX_W'(idx);
        #1;
        chk(m_if.rd_data_o);
    endtask

    // Capture shadows on a frozen edge so live counts are untouched.
    task automatic snap_main();
        m_if.freeze_i = 1'b1;
        m_if.snap_i   = 1'b1;
        cyc(1);
        m_if.snap_i   = 1'b0;
        m_if.freeze_i = 1'b0;
    endtask

    task automatic clear_main();
        m_if.clear_i = 1'b1;
        cyc(1);
        m_if.clear_i = 1'b0;
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        start   = 1'b0;
        m_if.clear_i = 0; m_if.freeze_i = 0; m_if.event_i = '0; m_if.snap_i = 0; m_if.rd_idx_i = '0;
        w_if.clear_i = 0; w_if.freeze_i = 0; w_if.event_i = '0; w_if.snap_i = 0; w_if.rd_idx_i = '0;
        s_if.clear_i = 0; s_if.freeze_i = 0; s_if.event_i = '0; s_if.snap_i = 0; s_if.rd_idx_i = '0;

        // Reset, then idle counting
        push("rst_cycle", 0); push("rst_done", 0); push("rst_ovf", 0);
        push("rst_snapv", 0); push("rst_rd4", 0);
        cyc(3);
        chk(m_if.cycle_o); chk(m_if.done_o); chk(m_if.ovf_o); chk(m_if.snap_valid_o);
        rd_main(4);

        start = 1'b1;
        push("idle_cycle", 10); push("idle_done", 0); push("idle_ovf", 0);
        cyc(10);
        chk(m_if.cycle_o); chk(m_if.done_o); chk(m_if.ovf_o);
        push("idle_snapv", 1);
        for (int k = 0; k < 4; k++) push($sformatf("idle_rd%0d", k), 0);
        push("idle_rd4", 10);
        snap_main();
        chk(m_if.snap_valid_o);
        for (int k = 0; k <= 4; k++) rd_main(k);

        // Mixed event pattern and snapshot read-out
        clear_main();
        push("clr_cycle", 0); push("clr_snapv", 0);
        chk(m_if.cycle_o); chk(m_if.snap_valid_o);
        push("pat_rd0", 4); push("pat_rd1", 8); push("pat_rd4", 8);
        push("pat_rd2", 0); push("pat_rd6", 0); push("pat_snapv", 1); push("pat_cycle", 9);
        for (int i = 0; i < 8; i++) begin
            m_if.event_i = {2'b00, 1'b1, (i % 2 == 0)};
            cyc(1);
        end
        m_if.event_i = '0;
        m_if.snap_i  = 1'b1;
        cyc(1);
        m_if.snap_i  = 1'b0;
        rd_main(0); rd_main(1); rd_main(4); rd_main(2); rd_main(6);
        chk(m_if.snap_valid_o); chk(m_if.cycle_o);

        // Cycle limit, hold in DONE, clear and resume
        clear_main();
        m_if.event_i = 4'hF;
        push("lim29_cycle", 29); push("lim29_done", 0);
        cyc(29);
        chk(m_if.cycle_o); chk(m_if.done_o);
        push("lim30_cycle", 30); push("lim30_done", 1);
        cyc(1);
        chk(m_if.cycle_o); chk(m_if.done_o);
        push("hold_cycle", 30); push("hold_done", 1);
        cyc(5);
        chk(m_if.cycle_o); chk(m_if.done_o);
        for (int k = 0; k < 4; k++) push($sformatf("hold_rd%0d", k), 30);
        push("hold_rd4", 30);
        m_if.snap_i = 1'b1;
        cyc(1);
        m_if.snap_i = 1'b0;
        for (int k = 0; k <= 4; k++) rd_main(k);
        push("lclr_cycle", 0); push("lclr_done", 0); push("lclr_snapv", 0);
        push("lclr_ovf", 0); push("lclr_rd0", 0);
        clear_main();
        chk(m_if.cycle_o); chk(m_if.done_o); chk(m_if.snap_valid_o); chk(m_if.ovf_o);
        rd_main(0);
        push("resume_cycle", 3); push("resume_done", 0); push("resume_rd2", 3);
        cyc(3);
        chk(m_if.cycle_o); chk(m_if.done_o);
        snap_main();
        rd_main(2);
        m_if.event_i = '0;

        // 4-bit counters: wrap versus saturate on channel 2
        w_if.clear_i = 1'b1; s_if.clear_i = 1'b1;
        w_if.event_i = 4'b0100; s_if.event_i = 4'b0100;
        cyc(1);
        w_if.clear_i = 1'b0; s_if.clear_i = 1'b0;
        push("wrap_rd2", 1); push("wrap_ovf", 4'b0100); push("wrap_cycle", 1); push("wrap_rd0", 0);
        push("sat_rd2", 15); push("sat_ovf", 4'b0100); push("sat_cycle", 1);
        cyc(17);
        w_if.event_i = '0; s_if.event_i = '0;
        w_if.freeze_i = 1'b1; s_if.freeze_i = 1'b1;
        w_if.snap_i = 1'b1; s_if.snap_i = 1'b1;
        cyc(1);
        w_if.snap_i = 1'b0; s_if.snap_i = 1'b0;
        w_if.rd_idx_i = IDX_W'(2); s_if.rd_idx_i = IDX_W'(2);
        #1;
        chk(w_if.rd_data_o); chk(w_if.ovf_o); chk(w_if.cycle_o);
        w_if.rd_idx_i = IDX_W'(0);
        #1;
        chk(w_if.rd_data_o);
        chk(s_if.rd_data_o); chk(s_if.ovf_o); chk(s_if.cycle_o);
        w_if.freeze_i = 1'b0; s_if.freeze_i = 1'b0;

        // Freeze suppression
        clear_main();
        m_if.event_i = 4'b1000;
        push("frz_cycle", 7); push("frz_rd3", 7); push("frz_rd0", 0);
        for (int i = 0; i < 12; i++) begin
            m_if.freeze_i = (i == 1 || i == 3 || i == 5 || i == 7 || i == 9);
            cyc(1);
        end
        m_if.freeze_i = 1'b0;
        m_if.event_i  = '0;
        snap_main();
        chk(m_if.cycle_o);
        rd_main(3); rd_main(0);

        // Mid-run reset
        clear_main();
        m_if.event_i = 4'hF;
        push("pre_rst_cycle", 12); push("pre_rst_rd0", 12); push("pre_rst_snapv", 1);
        cyc(12);
        chk(m_if.cycle_o);
        snap_main();
        rd_main(0);
        chk(m_if.snap_valid_o);
        push("mrst_cycle", 0); push("mrst_done", 0); push("mrst_ovf", 0);
        push("mrst_snapv", 0); push("mrst_rd0", 0);
        start = 1'b0;
        cyc(1);
        start = 1'b1;
        chk(m_if.cycle_o); chk(m_if.done_o); chk(m_if.ovf_o); chk(m_if.snap_valid_o);
        rd_main(0);
        push("restart_cycle", 3); push("restart_rd1", 3);
        cyc(3);
        chk(m_if.cycle_o);
        snap_main();
        rd_main(1);

        if (sb.size() != 0) begin
            vectors++;
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
